// File: rtl/axis_gain_offset_pipe_if.sv
// AXI-stream beat bundle used by the gain/offset pixel pipeline.
// master drives the beat (tvalid/tdata/tlast/tuser), slave returns tready.
interface axis_gain_offset_pipe_if #(
  parameter int DATA_W = 16,
  parameter int USER_W = 2
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic [USER_W-1:0] tuser;

  modport master (output tvalid, output tdata, output tlast, output tuser, input tready);
  modport slave  (input tvalid, input tdata, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_gain_offset_pipe.sv
// Elastic AXI-stream gain/offset pipeline with saturation, SOF-latched controls and frame-length check.
// Define AXIS_GAIN_OFFSET_PIPE_STATS_EN to add the frame_cnt / err_cnt statistics outputs.
module axis_gain_offset_pipe #(
  parameter int DATA_W    = 16,
  parameter int USER_W    = 2,
  parameter int STAGES    = 2,
  parameter int FRAC_W    = 3,
  parameter int FRAME_LEN = 100
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bypass,
  input  logic [DATA_W-1:0]            ctrl1,
  input  logic [DATA_W-1:0]            ctrl2,
  axis_gain_offset_pipe_if.slave       s,
  axis_gain_offset_pipe_if.master      m,
  output logic                         frame_done,
  output logic                         len_err
`ifdef AXIS_GAIN_OFFSET_PIPE_STATS_EN
  ,
  output logic [31:0]                  frame_cnt,
  output logic [15:0]                  err_cnt
`endif
);

  localparam int PW    = 2 * DATA_W;
  localparam int MID   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int CNT_W = $clog2(FRAME_LEN + 1) + 1;
  localparam logic [DATA_W-1:0] UNITY = DATA_W'(1 << FRAC_W);

  logic              acc, sof;
  logic              bypass_sh;
  logic [DATA_W-1:0] gain_sh, offset_sh;
  logic              eff_byp;
  logic [DATA_W-1:0] eff_gain, eff_off;
  logic [PW-1:0]     p_in;
  logic [DATA_W-1:0] off_in;

  logic [STAGES-1:0] v, ld, lst, in_v, in_l;
  logic [USER_W-1:0] usr [STAGES];
  logic [USER_W-1:0] in_u [STAGES];
  logic [PW-1:0]     in_p [STAGES];
  logic [DATA_W-1:0] in_off [STAGES];
  logic [PW-1:0]     p_q [MID];
  logic [DATA_W-1:0] off_q [MID];
  logic [DATA_W-1:0] dat_q;

  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              err_now;

  function automatic logic [DATA_W-1:0] sat_add(input logic [PW-1:0] p, input logic [DATA_W-1:0] off);
    logic [PW:0] y;
    y = {1'b0, p >> FRAC_W} + (PW+1)'(off);
    if (y > (PW+1)'({DATA_W{1'b1}})) return '1;
    return y[DATA_W-1:0];
  endfunction

  assign sof = s.tuser[0];
  assign acc = s.tvalid && s.tready;

  // An SOF beat uses the incoming controls directly, later beats use the shadows.
  // Bypass is folded into the datapath as (data << FRAC_W) + 0, so offset travels with each beat.
  always_comb begin
    eff_byp  = sof ? bypass : bypass_sh;
    eff_gain = sof ? ctrl1  : gain_sh;
    eff_off  = sof ? ctrl2  : offset_sh;
    if (eff_byp) begin
      p_in   = PW'(s.tdata) << FRAC_W;
      off_in = '0;
    end else begin
      p_in   = PW'(s.tdata) * PW'(eff_gain);
      off_in = eff_off;
    end
  end

  // Stage k may load if any stage at or after k is empty, or the output is taking.
  always_comb begin
    logic room;
    ld   = '0;
    room = m.tready;
    for (int unsigned i = 0; i < STAGES; i++) begin
      room               = room || !v[STAGES-1-i];
      ld[STAGES-1-i]     = room;
    end
  end

  always_comb begin
    in_v      = '0;
    in_l      = '0;
    in_u      = '{default: '0};
    in_p      = '{default: '0};
    in_off    = '{default: '0};
    in_v[0]   = s.tvalid;
    in_l[0]   = s.tlast;
    in_u[0]   = s.tuser;
    in_p[0]   = p_in;
    in_off[0] = off_in;
    for (int unsigned k = 1; k < STAGES; k++) begin
      in_v[k]   = v[k-1];
      in_l[k]   = lst[k-1];
      in_u[k]   = usr[k-1];
      in_p[k]   = p_q[k-1];
      in_off[k] = off_q[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v     <= '0;
      lst   <= '0;
      usr   <= '{default: '0};
      dat_q <= '0;
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ld[k]) v[k] <= in_v[k];
        if (ld[k] && in_v[k]) begin
          lst[k] <= in_l[k];
          usr[k] <= in_u[k];
        end
      end
      if (ld[STAGES-1] && in_v[STAGES-1])
        dat_q <= sat_add(in_p[STAGES-1], in_off[STAGES-1]);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k + 1 < STAGES; k++) begin
      if (ld[k] && in_v[k]) begin
        p_q[k]   <= in_p[k];
        off_q[k] <= in_off[k];
      end
    end
  end

  assign s.tready = ld[0];
  assign m.tvalid = v[STAGES-1];
  assign m.tdata  = dat_q;
  assign m.tlast  = lst[STAGES-1];
  assign m.tuser  = usr[STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      bypass_sh <= 1'b1;
      gain_sh   <= UNITY;
      offset_sh <= '0;
    end else if (acc && sof) begin
      bypass_sh <= bypass;
      gain_sh   <= ctrl1;
      offset_sh <= ctrl2;
    end
  end

  always_comb begin
    cnt_nxt = cnt;
    err_now = 1'b0;
    if (acc) begin
      if (sof) begin
        cnt_nxt = CNT_W'(1);
        err_now = (cnt != '0);
      end else if (cnt != '1) begin
        cnt_nxt = cnt + 1'b1;
      end
      if (s.tlast) err_now = err_now || (cnt_nxt != CNT_W'(FRAME_LEN));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      len_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      len_err    <= err_now;
      frame_done <= m.tvalid && m.tready && m.tlast;
      if (acc) cnt <= s.tlast ? '0 : cnt_nxt;
    end
  end

`ifdef AXIS_GAIN_OFFSET_PIPE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      if (frame_done) frame_cnt <= frame_cnt + 1'b1;
      if (len_err && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_gain_offset_pipe.sv
// Randomized self-checking bench for axis_gain_offset_pipe against a frame-level behavioural model.
module tb_axis_gain_offset_pipe;
  localparam int DW = 16, UW = 2, ST = 2, FW = 3, FL = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          bypass = 1'b0;
  logic [DW-1:0] ctrl1 = 16'd8, ctrl2 = 16'd0;
  logic          frame_done, len_err;
`ifdef AXIS_GAIN_OFFSET_PIPE_STATS_EN
  logic [31:0]   frame_cnt;
  logic [15:0]   err_cnt;
`endif

  axis_gain_offset_pipe_if #(.DATA_W(DW), .USER_W(UW)) s_if ();
  axis_gain_offset_pipe_if #(.DATA_W(DW), .USER_W(UW)) m_if ();

  axis_gain_offset_pipe #(
    .DATA_W(DW), .USER_W(UW), .STAGES(ST), .FRAC_W(FW), .FRAME_LEN(FL)
  ) dut (
    .clk(clk), .reset(reset), .bypass(bypass), .ctrl1(ctrl1), .ctrl2(ctrl2),
    .s(s_if), .m(m_if), .frame_done(frame_done), .len_err(len_err)
`ifdef AXIS_GAIN_OFFSET_PIPE_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, cycle = 0;
  int fd_seen = 0, le_seen = 0, first_lat = -1;
  bit rdy_mode = 1'b0;

  typedef struct { logic [15:0] d; logic l; logic [1:0] u; int t; } exp_t;
  exp_t          q[$];
  logic [15:0]   got_log[$];
  logic          got_l[$];

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cycle);
    end
  endtask

  // Spec-level pixel rule: bypass or floor(d*g / 2^FW) + o, clamped to 16 bits.
  function automatic logic [15:0] mdl(input int unsigned d, input int unsigned g,
                                      input int unsigned o, input bit byp);
    longint unsigned y;
    if (byp) return d[15:0];
    y = ((longint'(d) * longint'(g)) >> FW) + longint'(o);
    return (y > 65535) ? 16'hFFFF : y[15:0];
  endfunction

  // Behavioural model state: SOF-latched settings and beats-in-frame count.
  bit          m_byp = 1'b1;
  int unsigned m_gain = 8, m_off = 0;
  int          mcnt = 0;
  bit          exp_fd = 1'b0, exp_le = 1'b0, prev_stall = 1'b0;
  logic [15:0] pd; logic pl; logic [1:0] pu;

  always @(negedge clk) begin
    cycle++;
    if (reset) begin
      q.delete();
      mcnt = 0; m_byp = 1'b1; m_gain = 8; m_off = 0;
      exp_fd = 1'b0; exp_le = 1'b0; prev_stall = 1'b0;
    end else begin
      chk("frame_done", frame_done, exp_fd);
      chk("len_err", len_err, exp_le);
      if (frame_done) fd_seen++;
      if (len_err) le_seen++;
      if (prev_stall) begin
        chk("stall_valid", m_if.tvalid, 1);
        chk("stall_data", m_if.tdata, pd);
        chk("stall_last", m_if.tlast, pl);
        chk("stall_user", m_if.tuser, pu);
      end
      exp_fd = 1'b0;
      exp_le = 1'b0;
      if (s_if.tvalid && s_if.tready) begin
        exp_t e;
        int   n;
        bit   err;
        err = 1'b0;
        if (s_if.tuser[0]) begin
          m_byp = bypass; m_gain = ctrl1; m_off = ctrl2;
          err = (mcnt != 0);
          n = 1;
        end else n = mcnt + 1;
        if (s_if.tlast) begin
          if (n != FL) err = 1'b1;
          mcnt = 0;
        end else mcnt = n;
        exp_le = err;
        e.d = mdl(s_if.tdata, m_gain, m_off, m_byp);
        e.l = s_if.tlast; e.u = s_if.tuser; e.t = cycle;
        q.push_back(e);
      end
      if (m_if.tvalid && m_if.tready) begin
        if (q.size() == 0) begin
          chk("unexpected_output", m_if.tdata, -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("m_tdata", m_if.tdata, e.d);
          chk("m_tlast", m_if.tlast, e.l);
          chk("m_tuser", m_if.tuser, e.u);
          if (first_lat < 0) first_lat = cycle - e.t;
          got_log.push_back(m_if.tdata);
          got_l.push_back(m_if.tlast);
          exp_fd = e.l;
        end
      end
      prev_stall = m_if.tvalid && !m_if.tready;
      pd = m_if.tdata; pl = m_if.tlast; pu = m_if.tuser;
    end
  end

  initial m_if.tready = 1'b1;
  always @(posedge clk) begin
    #1;
    m_if.tready = rdy_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic send_beat(input logic [15:0] d, input bit sof, input bit last);
    bit   ok;
    logic u1;
    u1 = 1'($urandom_range(0, 1));
    ok = 1'b0;
    s_if.tvalid = 1'b1; s_if.tdata = d; s_if.tlast = last; s_if.tuser = {u1, sof};
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      ok = s_if.tready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    if (!ok) chk("s_tready_timeout", 0, 1);
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tuser = '0;
  endtask

  task automatic send_frame(input int n, input bit sof, input bit last,
                            input int unsigned first_d, input bit rnd);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      d = (i == 0 || !rnd) ? 16'(first_d + i) : 16'($urandom_range(0, 65535));
      send_beat(d, sof && i == 0, last && i == n - 1);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 1000; n++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    repeat (3) begin @(posedge clk); #1; end
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic clear_log();
    got_log.delete(); got_l.delete();
  endtask

  int fd0, le0;

  initial begin
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    chk("rst_m_tvalid", m_if.tvalid, 0);
    chk("rst_m_tdata", m_if.tdata, 0);
    chk("rst_m_tlast", m_if.tlast, 0);
    chk("rst_m_tuser", m_if.tuser, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_s_tready", s_if.tready, 1);

    chk("model_offset", mdl(0, 8, 10, 0), 10);
    chk("model_gain", mdl(100, 10, 0, 0), 125);
    chk("model_sat", mdl(60000, 16, 0, 0), 65535);
    chk("model_bypass", mdl(7, 8, 10, 1), 7);

    // Unity gain plus offset, 0..99
    ctrl1 = 16'd8; ctrl2 = 16'd10; bypass = 1'b0;
    clear_log(); first_lat = -1; fd0 = fd_seen; le0 = le_seen;
    send_frame(100, 1, 1, 0, 0);
    drain();
    chk("t1_count", got_log.size(), 100);
    chk("t1_first", got_log[0], 10);
    chk("t1_last", got_log[99], 109);
    chk("t1_tlast99", got_l[99], 1);
    chk("t1_tlast98", got_l[98], 0);
    chk("t1_latency", first_lat, ST);
    chk("t1_frame_done", fd_seen - fd0, 1);
    chk("t1_len_err", le_seen - le0, 0);

    // Gain and saturation
    ctrl1 = 16'd10; ctrl2 = 16'd0;
    clear_log();
    send_frame(100, 1, 1, 100, 1);
    drain();
    chk("t2_gain", got_log[0], 125);
    ctrl1 = 16'd16;
    clear_log();
    send_frame(100, 1, 1, 60000, 1);
    drain();
    chk("t2_sat", got_log[0], 65535);

    // Shadowing: bypass raised mid-frame only takes effect at next SOF
    ctrl1 = 16'd8; ctrl2 = 16'd10; bypass = 1'b0;
    clear_log();
    for (int i = 0; i < 100; i++) begin
      if (i == 50) bypass = 1'b1;
      send_beat(16'(i * 3), i == 0, i == 99);
    end
    drain();
    chk("t3_still_processed", got_log[60], 190);
    clear_log();
    send_frame(100, 1, 1, 500, 0);
    drain();
    chk("t3_bypassed", got_log[10], 510);

    // Random backpressure
    bypass = 1'b0; ctrl1 = 16'd12; ctrl2 = 16'd7;
    clear_log(); rdy_mode = 1'b1;
    send_frame(100, 1, 1, 1234, 1);
    drain();
    rdy_mode = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    chk("t4_count", got_log.size(), 100);

    // Length errors: short frame, then SOF without prior tlast
    le0 = le_seen; fd0 = fd_seen;
    send_frame(99, 1, 1, 0, 1);
    drain();
    chk("t5_short_err", le_seen - le0, 1);
    chk("t5_short_done", fd_seen - fd0, 1);
    send_frame(40, 1, 0, 0, 1);
    send_frame(100, 1, 1, 0, 1);
    drain();
    chk("t5_sof_err", le_seen - le0, 2);
`ifdef AXIS_GAIN_OFFSET_PIPE_STATS_EN
    chk("t5_err_cnt", err_cnt, 2);
    chk("t5_frame_cnt", frame_cnt, 8);
`endif

    // Reset mid-frame at beat 30
    ctrl1 = 16'd16; ctrl2 = 16'd0; bypass = 1'b0;
    send_frame(30, 1, 0, 0, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("t6_m_tvalid", m_if.tvalid, 0);
    chk("t6_m_tdata", m_if.tdata, 0);
    chk("t6_m_tlast", m_if.tlast, 0);
    chk("t6_frame_done", frame_done, 0);
    chk("t6_len_err", len_err, 0);
    le0 = le_seen; fd0 = fd_seen;
    clear_log();
    send_frame(100, 0, 1, 1000, 0);
    drain();
    chk("t6_shadow_bypass", got_log[5], 1005);
    clear_log();
    send_frame(100, 1, 1, 1000, 0);
    drain();
    chk("t6_processed", got_log[0], 2000);
    chk("t6_len_err_cnt", le_seen - le0, 0);
    chk("t6_frame_done_cnt", fd_seen - fd0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/axis_gain_offset_pipe.md
Name: axis_gain_offset_pipe

Overview:
- Parametrised AXI-stream pixel pipeline: per-beat unsigned gain/offset with saturation, or bypass.
- Control values are latched at start-of-frame, so frames are never processed with mixed settings.
- Checks frame length and pulses status on frame completion and length error.
- Sits between the input and output stream FIFOs of the simple-pipeline top, in place of the fixed wire stage.

Parameters:
- DATA_W, 16, width of tdata, ctrl1 (gain) and ctrl2 (offset).
- USER_W, 2, tuser width; bit 0 = start-of-frame (SOF).
- STAGES, 2, pipeline depth (>=1) = latency in cycles.
- FRAC_W, 3, fractional bits of gain; gain 1<<FRAC_W = unity.
- FRAME_LEN, 100, expected beats per frame.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- bypass  in  1  1 = pass data unchanged
- ctrl1  in  DATA_W  gain, unsigned fixed point, FRAC_W fraction bits
- ctrl2  in  DATA_W  offset, unsigned
- s_tready  out  1  input accept
- s_tvalid  in  1  input beat valid
- s_tdata  in  DATA_W  input pixel
- s_tlast  in  1  last beat of frame
- s_tuser  in  USER_W  bit0 SOF
- m_tready  in  1  output accept
- m_tvalid  out  1  output beat valid
- m_tdata  out  DATA_W  processed pixel
- m_tlast  out  1  delayed s_tlast
- m_tuser  out  USER_W  delayed s_tuser
- frame_done  out  1  1-cycle pulse when a tlast beat is accepted at the output
- len_err  out  1  1-cycle pulse on frame-length violation

Behaviour:
- Reset values:
  - All stage valids = 0, so m_tvalid = 0.
  - m_tdata, m_tlast, m_tuser = 0.
  - frame_done = 0, len_err = 0, beat counter = 0.
  - Shadow registers: bypass_sh = 1, gain_sh = 1<<FRAC_W, offset_sh = 0.
- Input acceptance: a beat is accepted when s_tvalid && s_tready.
- Control shadowing: on an accepted beat with s_tuser[0] = 1, the shadows load bypass/ctrl1/ctrl2, and that same beat uses the new values. Control changes at any other time have no effect until the next SOF.
- Arithmetic:
  - p = s_tdata * gain_sh (2*DATA_W bits).
  - y = (p >> FRAC_W) + offset_sh, computed at full width.
  - If y > 2^DATA_W-1, output 2^DATA_W-1; else y[DATA_W-1:0].
  - With bypass_sh = 1, output = s_tdata.
  - The multiply is registered in stage 1, add/saturate in the last stage. If STAGES = 1, both are done in one stage.
- Pipeline:
  - Elastic chain of STAGES registers, each with its own valid bit. tlast and tuser travel aligned with tdata.
  - Stage k loads when it is empty or when stage k+1 (or the output, for the last stage) takes its content.
  - s_tready = !v[0] || stage0_advances. It is combinational from m_tready through the chain.
  - Throughput 1 beat/clk when m_tready = 1; latency STAGES cycles from accept to m_tvalid.
  - Bubbles collapse: an empty stage accepts new data even while downstream is stalled.
  - m_* hold stable while m_tvalid && !m_tready.
- Frame length check (at input):
  - The counter increments on each accepted beat.
  - An SOF beat sets the counter to 1. If the counter was nonzero (previous frame lacked tlast), len_err pulses.
  - An accepted tlast beat: if count+1 != FRAME_LEN, len_err pulses. The counter then clears to 0.
  - Counter width is clog2(FRAME_LEN+1)+1 bits, saturating at max.
  - SOF and tlast on the same beat: the frame length is 1 and is checked against FRAME_LEN.
- frame_done is asserted the cycle after m_tvalid && m_tready && m_tlast.
- Reset mid-frame: in-flight data is discarded; no frame_done or len_err is produced for that frame.

Optional Feature:
- Macro AXIS_GAIN_OFFSET_PIPE_STATS_EN.
- Defined:
  - Adds output frame_cnt[31:0]: increments on each frame_done, wraps.
  - Adds output err_cnt[15:0]: increments on each len_err, saturates at 16'hFFFF.
  - Both counters reset to 0.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Unity/offset: ctrl1 = 8, ctrl2 = 10, bypass = 0, frame of 100 beats with data 0..99, m_tready = 1 -> output 10..109, m_tlast on beat 99, frame_done once, len_err never, latency 2 cycles.
- Gain and saturation: ctrl1 = 10, ctrl2 = 0 -> input 100 gives 125. ctrl1 = 16, input 60000 -> 65535.
- Shadowing: set bypass = 1 at beat 50 of a frame -> that frame stays processed. The next frame (after its SOF) is output equal to input.
- Backpressure: m_tready toggles 1-0-0-1 randomly for one frame -> no beat lost or duplicated, m_* stable while stalled, output sequence unchanged.
- Length errors:
  - 99-beat frame with tlast -> len_err pulse.
  - SOF arriving at beat 40 without a prior tlast -> len_err pulse, and the new frame is counted from 1.
  - With STATS_EN, err_cnt = 2.
- Reset at beat 30 of a frame -> m_tvalid = 0 the next cycle, shadows back to bypass = 1, next full frame is clean.
